// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// One access is in flight at a time. Each access runs IDLE -> ACCESS -> RESP.
// A rejected access (out of range, illegal size or misaligned) skips ACCESS
// and never reaches the memory.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration. Without it,
// m0 has fixed priority.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   mN_req/we/size/addr/wdata       requester N access (size: 01 word, 10 half, 11 byte)
//   mN_done/rdata/err               one-cycle completion pulse with load data / reject flag
//   mem_ena/wena/w_cs/r_cs/addr/wdata  memory command, zero outside ACCESS
//   mem_rdata                       combinational load data from memory
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic [1:0]  mem_w_cs,
  output logic [1:0]  mem_r_cs,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0]  SZ_WORD    = 2'b01;
  localparam logic [1:0]  SZ_HALF    = 2'b10;
  localparam logic [1:0]  SZ_BYTE    = 2'b11;
  // One past the last valid byte; 33 bits so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;

  logic        m0_done_d, m1_done_d, m0_err_d, m1_err_d;
  logic [31:0] m0_rdata_d, m1_rdata_d;
  logic        mem_ena_d, mem_wena_d;
  logic [1:0]  mem_w_cs_d, mem_r_cs_d;
  logic [31:0] mem_addr_d, mem_wdata_d;

  logic        win_m1;
  logic        win_we;
  logic [1:0]  win_size;
  logic [31:0] win_addr, win_wdata;
  logic        win_reject;
  logic [31:0] load_data;

`ifdef DMEM_ARB_RR_EN
  // 1 = m1 was granted last; the other requester wins a tie.
  logic last_q, last_d;
  assign win_m1 = m1_req && (!m0_req || !last_q);
`else
  assign win_m1 = m1_req && !m0_req;
`endif

  // Winner field mux and legality check.
  always_comb begin
    win_we     = win_m1 ? m1_we    : m0_we;
    win_size   = win_m1 ? m1_size  : m0_size;
    win_addr   = win_m1 ? m1_addr  : m0_addr;
    win_wdata  = win_m1 ? m1_wdata : m0_wdata;
    win_reject = ({1'b0, win_addr} < 33'(BASE_ADDR)) || ({1'b0, win_addr} >= ADDR_LIMIT)
              || (win_size == 2'b00)
              || ((win_size == SZ_WORD) && (win_addr[1:0] != 2'b00))
              || ((win_size == SZ_HALF) && win_addr[0]);
  end

  // Load data masked to the access width, zero-extended.
  always_comb begin
    case (size_q)
      SZ_WORD: load_data = mem_rdata;
      SZ_HALF: load_data = {16'h0000, mem_rdata[15:0]};
      SZ_BYTE: load_data = {24'h000000, mem_rdata[7:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Next-state and next-output logic; every output is zero unless set here.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    size_d      = size_q;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = 32'h0000_0000;
    m1_rdata_d  = 32'h0000_0000;
    mem_ena_d   = 1'b0;
    mem_wena_d  = 1'b0;
    mem_w_cs_d  = 2'b00;
    mem_r_cs_d  = 2'b00;
    mem_addr_d  = 32'h0000_0000;
    mem_wdata_d = 32'h0000_0000;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          id_d   = win_m1;
          we_d   = win_we;
          size_d = win_size;
`ifdef DMEM_ARB_RR_EN
          last_d = win_m1;
`endif
          if (win_reject) begin
            state_d   = RESP;
            m0_done_d = !win_m1;
            m0_err_d  = !win_m1;
            m1_done_d = win_m1;
            m1_err_d  = win_m1;
          end else begin
            state_d     = ACCESS;
            mem_ena_d   = 1'b1;
            mem_wena_d  = win_we;
            mem_w_cs_d  = win_we ? win_size : 2'b00;
            mem_r_cs_d  = win_we ? 2'b00 : win_size;
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (id_q) begin
          m1_done_d  = 1'b1;
          m1_rdata_d = we_q ? 32'h0000_0000 : load_data;
        end else begin
          m0_done_d  = 1'b1;
          m0_rdata_d = we_q ? 32'h0000_0000 : load_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= 32'h0000_0000;
      m1_rdata  <= 32'h0000_0000;
      mem_ena   <= 1'b0;
      mem_wena  <= 1'b0;
      mem_w_cs  <= 2'b00;
      mem_r_cs  <= 2'b00;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
`ifdef DMEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      we_q      <= we_d;
      size_q    <= size_d;
      m0_done   <= m0_done_d;
      m1_done   <= m1_done_d;
      m0_err    <= m0_err_d;
      m1_err    <= m1_err_d;
      m0_rdata  <= m0_rdata_d;
      m1_rdata  <= m1_rdata_d;
      mem_ena   <= mem_ena_d;
      mem_wena  <= mem_wena_d;
      mem_w_cs  <= mem_w_cs_d;
      mem_r_cs  <= mem_r_cs_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
`ifdef DMEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural little-endian memory plus a scoreboard of
// expected completions (requester, err, rdata, cycle of the done pulse).
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ena, mem_wena;
  logic [1:0]  mem_w_cs, mem_r_cs;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_w_cs(mem_w_cs), .mem_r_cs(mem_r_cs),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: returns the addressed lane right-aligned, stores by lane.
  logic [31:0] mem [DEPTH];
  logic [9:0]  midx;
  assign midx      = 10'((mem_addr - BASE) >> 2);
  assign mem_rdata = mem[midx] >> {mem_addr[1:0], 3'b000};

  always @(posedge clk) begin
    if (mem_ena && mem_wena) begin
      case (mem_w_cs)
        2'b01:   mem[midx] <= mem_wdata;
        2'b10:   mem[midx][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        2'b11:   mem[midx][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  typedef struct {
    bit          id;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  ena_cnt = 0;

  logic [137:0] all_outs;
  assign all_outs = {m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
                     mem_ena, mem_wena, mem_w_cs, mem_r_cs, mem_addr, mem_wdata};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Completion monitor: every done pulse is checked against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (mem_ena === 1'b1) ena_cnt++;
    if (m0_done === 1'b1 || m1_done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: m0_done=%0b m1_done=%0b at cyc %0d, want no done", m0_done, m1_done, cyc);
      end else begin
        sb_t e;
        logic        x0d, x1d, x0e, x1e;
        logic [31:0] x0r, x1r;
        e   = sb.pop_front();
        x0d = !e.id;
        x1d = e.id;
        x0e = e.id ? 1'b0 : e.err;
        x1e = e.id ? e.err : 1'b0;
        x0r = e.id ? 32'h0 : e.rdata;
        x1r = e.id ? e.rdata : 32'h0;
        if (m0_done !== x0d || m1_done !== x1d || m0_err !== x0e || m1_err !== x1e ||
            m0_rdata !== x0r || m1_rdata !== x1r || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL done_pkt: got m0(d=%0b e=%0b r=%h) m1(d=%0b e=%0b r=%h) cyc=%0d, want m0(d=%0b e=%0b r=%h) m1(d=%0b e=%0b r=%h) cyc=%0d",
                   m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata, cyc,
                   x0d, x0e, x0r, x1d, x1e, x1r, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  // Issue one access right after an edge, hold it until its done has been seen.
  task automatic run_access(input bit id, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit exp_err, input logic [31:0] exp_rdata);
    sb_t e;
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    if (id) begin
      m1_req = 1'b1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
    end
    e.id = id; e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + (exp_err ? 1 : 2);
    sb.push_back(e);
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: m%0d addr=%h still pending, want done", id, addr);
      sb.delete();
    end
  endtask

  task automatic release_all();
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_size = 2'b00; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_size = 2'b00; m1_addr = 32'h0; m1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    run_access(1'b0, 1'b1, 2'b01, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run_access(1'b0, 1'b0, 2'b01, 32'h1001_0008, 32'h0, 1'b0, 32'hDEAD_BEEF);
    release_all();
  endtask

  task automatic test_byte();
    run_access(1'b1, 1'b1, 2'b11, 32'h1001_0013, 32'h0000_00A5, 1'b0, 32'h0);
    run_access(1'b1, 1'b0, 2'b01, 32'h1001_0010, 32'h0, 1'b0, 32'hA500_0000);
    run_access(1'b1, 1'b0, 2'b11, 32'h1001_0013, 32'h0, 1'b0, 32'h0000_00A5);
    release_all();
  endtask

  task automatic test_mask();
    run_access(1'b0, 1'b0, 2'b11, 32'h1001_0008, 32'h0, 1'b0, 32'h0000_00EF);
    run_access(1'b0, 1'b0, 2'b10, 32'h1001_000A, 32'h0, 1'b0, 32'h0000_DEAD);
    run_access(1'b0, 1'b0, 2'b10, 32'h1001_0008, 32'h0, 1'b0, 32'h0000_BEEF);
    release_all();
  endtask

  task automatic test_reject();
    int ena0;
    ena0 = ena_cnt;
    run_access(1'b0, 1'b0, 2'b01, 32'h1001_0002, 32'h0, 1'b1, 32'h0);
    run_access(1'b1, 1'b0, 2'b01, 32'h1001_1000, 32'h0, 1'b1, 32'h0);
    run_access(1'b1, 1'b0, 2'b01, 32'h1000_FFFC, 32'h0, 1'b1, 32'h0);
    run_access(1'b0, 1'b1, 2'b00, 32'h1001_0000, 32'h1234_5678, 1'b1, 32'h0);
    run_access(1'b1, 1'b1, 2'b10, 32'h1001_0001, 32'h1234_5678, 1'b1, 32'h0);
    release_all();
    vectors++;
    if (ena_cnt != ena0) begin
      miscompares++;
      $display("FAIL reject_mem_ena: %0d enabled cycles, want 0", ena_cnt - ena0);
    end
  endtask

  task automatic test_boundary();
    run_access(1'b0, 1'b1, 2'b01, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0);
    run_access(1'b1, 1'b0, 2'b01, 32'h1001_0FFC, 32'h0, 1'b0, 32'hCAFE_F00D);
    run_access(1'b0, 1'b0, 2'b01, 32'h1001_0000, 32'h0, 1'b0, 32'h0);
    release_all();
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b1, 2'b10, 32'h1001_0016, 32'hFFFF_1234, 1'b0, 32'h0);
    run_access(1'b0, 1'b0, 2'b01, 32'h1001_0014, 32'h0, 1'b0, 32'h1234_0000);
    run_access(1'b1, 1'b0, 2'b10, 32'h1001_0016, 32'h0, 1'b0, 32'h0000_1234);
    run_access(1'b0, 1'b0, 2'b11, 32'h1001_0017, 32'h0, 1'b0, 32'h0000_0012);
    release_all();
  endtask

  task automatic test_arbitration();
    sb_t e;
    int  p;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_size = 2'b01; m0_addr = 32'h1001_0008; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_size = 2'b01; m1_addr = 32'h1001_0010; m1_wdata = 32'h0;
    p = cyc;
    for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_RR_EN
      e.id = (k % 2) == 1;
`else
      e.id = 1'b0;
`endif
      e.err   = 1'b0;
      e.rdata = e.id ? 32'hA500_0000 : 32'hDEAD_BEEF;
      e.cyc   = p + 2 + 3 * k;
      sb.push_back(e);
    end
    for (int i = 0; i < 15 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL arb_timeout: %0d grants missing, want 0", sb.size());
      sb.delete();
    end
    release_all();
  endtask

  task automatic test_reset_in_access();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_size = 2'b01; m0_addr = 32'h1001_0008; m0_wdata = 32'h0;
    @(posedge clk); #1;
    vectors++;
    if (mem_ena !== 1'b1) begin
      miscompares++;
      $display("FAIL access_mem_ena: got %b, want 1", mem_ena);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_in_access_outputs: got %h, want 0", all_outs);
    end
    repeat (2) @(posedge clk);
    run_access(1'b0, 1'b0, 2'b01, 32'h1001_0008, 32'h0, 1'b0, 32'hDEAD_BEEF);
    release_all();
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;
    test_reset();
    test_store_load();
    test_byte();
    test_mask();
    test_reject();
    test_boundary();
    test_back_to_back();
    test_arbitration();
    test_reset_in_access();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
